// File: rtl/vchannel_fifo_bank_if.sv
// rtl/vchannel_fifo_bank_if.sv - push/pop handshake and status bundle for the VC FIFO bank
interface vchannel_fifo_bank_if #(
    parameter int DATA_W = 8
);
    logic              push;
    logic [1:0]        push_vc;
    logic [DATA_W-1:0] data_in;
    logic [3:0]        pop_req;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              empty_vchannel0;
    logic              empty_vchannel1;
    logic              empty_vchannel2;
    logic              empty_vchannel3;
    logic [3:0]        full_vc;
    logic [3:0]        afull_vc;
    logic              err_overflow;
    logic              err_underflow;
    logic              err_pop;

    modport master (
        output push, push_vc, data_in, pop_req,
        input  data_out, valid_out,
        input  empty_vchannel0, empty_vchannel1, empty_vchannel2, empty_vchannel3,
        input  full_vc, afull_vc, err_overflow, err_underflow, err_pop
    );

    modport slave (
        input  push, push_vc, data_in, pop_req,
        output data_out, valid_out,
        output empty_vchannel0, empty_vchannel1, empty_vchannel2, empty_vchannel3,
        output full_vc, afull_vc, err_overflow, err_underflow, err_pop
    );
endinterface

// File: rtl/vchannel_fifo_bank.sv
// rtl/vchannel_fifo_bank.sv - four virtual-channel FIFOs feeding a one-hot-grant arbiter
module vchannel_fifo_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AF_LVL = 3
) (
    input  logic                 clk0,
    input  logic                 rst,
    input  logic                 enb,
    vchannel_fifo_bank_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [4][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [4];
    logic [PTR_W-1:0]  rd_ptr [4];
    logic [CNT_W-1:0]  count [4];
    logic [CNT_W-1:0]  count_nxt [4];

    logic [3:0]        empty_q;
    logic [3:0]        full_q;
    logic [3:0]        afull_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              ovf_q;
    logic              unf_q;
    logic              perr_q;

    logic              pop_any;
    logic              pop_multi;
    logic [1:0]        pop_idx;
    logic              do_push;
    logic              push_drop;
    logic              do_pop;
    logic              pop_empty;
    logic              pop_bad;
    logic [3:0]        push_sel;
    logic [3:0]        pop_sel;

    // Grant decode; x & (x-1) is non-zero exactly when more than one bit is set.
    always_comb begin
        pop_any   = |bus.pop_req;
        pop_multi = (bus.pop_req & (bus.pop_req - 4'd1)) != 4'd0;
        pop_idx   = 2'd0;
        case (bus.pop_req)
            4'b0010: pop_idx = 2'd1;
            4'b0100: pop_idx = 2'd2;
            4'b1000: pop_idx = 2'd3;
            default: pop_idx = 2'd0;
        endcase
    end

    // Push and pop are both judged on the registered (pre-edge) flags.
    always_comb begin
        do_push   = enb & bus.push & ~full_q[bus.push_vc];
        push_drop = enb & bus.push &  full_q[bus.push_vc];
        do_pop    = enb & pop_any & ~pop_multi & ~empty_q[pop_idx];
        pop_empty = enb & pop_any & ~pop_multi &  empty_q[pop_idx];
        pop_bad   = enb & pop_multi;
        push_sel  = do_push ? (4'b0001 << bus.push_vc) : 4'b0000;
        pop_sel   = do_pop  ? (4'b0001 << pop_idx)     : 4'b0000;
    end

    always_comb begin
        for (int v = 0; v < 4; v++) begin
            count_nxt[v] = count[v] + CNT_W'(push_sel[v]) - CNT_W'(pop_sel[v]);
        end
    end

    always_ff @(posedge clk0) begin
        if (!rst) begin
            for (int v = 0; v < 4; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            empty_q <= 4'hF;
            full_q  <= 4'h0;
            afull_q <= 4'h0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            for (int v = 0; v < 4; v++) begin
                if (push_sel[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
                end
                if (pop_sel[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
                end
                count[v]   <= count_nxt[v];
                empty_q[v] <= (count_nxt[v] == '0);
                full_q[v]  <= (count_nxt[v] == CNT_W'(DEPTH));
                afull_q[v] <= (count_nxt[v] >= CNT_W'(AF_LVL));
            end
            if (do_pop) begin
                data_q <= mem[pop_idx][rd_ptr[pop_idx]];
            end
            valid_q <= do_pop;
            ovf_q   <= push_drop;
            unf_q   <= pop_empty;
            perr_q  <= pop_bad;
        end
    end

    // Storage is not reset; a slot read in the same cycle it is written cannot occur
    // because a pop needs count>0 and a push needs count<DEPTH on the same VC.
    always_ff @(posedge clk0) begin
        if (rst && do_push) begin
            mem[bus.push_vc][wr_ptr[bus.push_vc]] <= bus.data_in;
        end
    end

    assign bus.data_out        = data_q;
    assign bus.valid_out       = valid_q;
    assign bus.empty_vchannel0 = empty_q[0];
    assign bus.empty_vchannel1 = empty_q[1];
    assign bus.empty_vchannel2 = empty_q[2];
    assign bus.empty_vchannel3 = empty_q[3];
    assign bus.full_vc         = full_q;
    assign bus.afull_vc        = afull_q;
    assign bus.err_overflow    = ovf_q;
    assign bus.err_underflow   = unf_q;
    assign bus.err_pop         = perr_q;
endmodule

// File: tb/tb_vchannel_fifo_bank.sv
// tb/tb_vchannel_fifo_bank.sv - queue-model bench with directed and random traffic
module tb_vchannel_fifo_bank;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int AF_LVL = 3;

    logic clk0 = 1'b0;
    logic rst  = 1'b0;
    logic enb  = 1'b0;

    vchannel_fifo_bank_if #(.DATA_W(DATA_W)) bus ();

    vchannel_fifo_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) dut (
        .clk0 (clk0),
        .rst  (rst),
        .enb  (enb),
        .bus  (bus)
    );

    always #5 clk0 = ~clk0;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    logic [DATA_W-1:0] q [4][$];
    logic [DATA_W-1:0] exp_data;
    logic              exp_valid;
    logic              exp_of;
    logic              exp_uf;
    logic              exp_ep;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: each VC is a plain queue; decisions use sizes before the edge.
    task automatic model_step();
        int sz [4];
        int ones;
        int idx;
        if (!rst) begin
            for (int v = 0; v < 4; v++) q[v].delete();
            exp_data = '0; exp_valid = 0; exp_of = 0; exp_uf = 0; exp_ep = 0;
            return;
        end
        exp_valid = 0; exp_of = 0; exp_uf = 0; exp_ep = 0;
        if (!enb) return;
        for (int v = 0; v < 4; v++) sz[v] = q[v].size();
        ones = $countones(bus.pop_req);
        if (ones > 1) begin
            exp_ep = 1;
        end else if (ones == 1) begin
            idx = 0;
            for (int v = 0; v < 4; v++) if (bus.pop_req[v]) idx = v;
            if (sz[idx] == 0) exp_uf = 1;
            else begin
                exp_data  = q[idx].pop_front();
                exp_valid = 1;
            end
        end
        if (bus.push) begin
            if (sz[bus.push_vc] < DEPTH) q[bus.push_vc].push_back(bus.data_in);
            else exp_of = 1;
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic p, input logic [1:0] vc,
                       input logic [7:0] d, input logic [3:0] pr);
        rst = r; enb = e;
        bus.push = p; bus.push_vc = vc; bus.data_in = d; bus.pop_req = pr;
        @(posedge clk0);
        model_step();
        #1;
    endtask

    always @(negedge clk0) begin
        if (chk_on) begin
            logic [3:0] ef, ff, af;
            for (int v = 0; v < 4; v++) begin
                ef[v] = (q[v].size() == 0);
                ff[v] = (q[v].size() == DEPTH);
                af[v] = (q[v].size() >= AF_LVL);
            end
            chk("valid_out", 32'(bus.valid_out), 32'(exp_valid));
            chk("data_out", 32'(bus.data_out), 32'(exp_data));
            chk("empty", 32'({bus.empty_vchannel3, bus.empty_vchannel2,
                              bus.empty_vchannel1, bus.empty_vchannel0}), 32'(ef));
            chk("full_vc", 32'(bus.full_vc), 32'(ff));
            chk("afull_vc", 32'(bus.afull_vc), 32'(af));
            chk("err_overflow", 32'(bus.err_overflow), 32'(exp_of));
            chk("err_underflow", 32'(bus.err_underflow), 32'(exp_uf));
            chk("err_pop", 32'(bus.err_pop), 32'(exp_ep));
        end
    end

    initial begin
        logic [3:0] pr;
        int r;
        bus.push = 0; bus.push_vc = 0; bus.data_in = 0; bus.pop_req = 0;

        // T1 reset with push asserted
        cyc(0, 1, 1, 2'd0, 8'h55, 4'b0000);
        chk_on = 1'b1;
        cyc(0, 1, 1, 2'd0, 8'h55, 4'b0000);
        chk("t1_empty0", 32'(bus.empty_vchannel0), 32'd1);
        chk("t1_full", 32'(bus.full_vc), 32'd0);
        chk("t1_valid", 32'(bus.valid_out), 32'd0);
        cyc(1, 1, 0, 2'd0, 8'h00, 4'b0000);
        chk("t1_no_write", 32'(bus.empty_vchannel0), 32'd1);

        // T2 basic
        cyc(1, 1, 1, 2'd2, 8'hA1, 4'b0000);
        cyc(1, 1, 1, 2'd2, 8'hA2, 4'b0000);
        cyc(1, 1, 0, 2'd0, 8'h00, 4'b0100);
        chk("t2_valid1", 32'(bus.valid_out), 32'd1);
        chk("t2_data1", 32'(bus.data_out), 32'hA1);
        cyc(1, 1, 0, 2'd0, 8'h00, 4'b0100);
        chk("t2_data2", 32'(bus.data_out), 32'hA2);
        cyc(1, 1, 0, 2'd0, 8'h00, 4'b0000);
        chk("t2_empty2", 32'(bus.empty_vchannel2), 32'd1);
        chk("t2_valid_low", 32'(bus.valid_out), 32'd0);

        // T3 fill VC0
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 2'd0, 8'(8'h10 + i), 4'b0000);
            if (i == 2) begin
                chk("t3_afull", 32'(bus.afull_vc[0]), 32'd1);
                chk("t3_not_full", 32'(bus.full_vc[0]), 32'd0);
            end
        end
        chk("t3_full", 32'(bus.full_vc[0]), 32'd1);
        cyc(1, 1, 1, 2'd0, 8'h14, 4'b0000);
        chk("t3_overflow", 32'(bus.err_overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 2'd0, 8'h00, 4'b0001);
            chk("t3_pop_data", 32'(bus.data_out), 32'(8'h10 + i));
            if (i == 0) chk("t3_overflow_pulse", 32'(bus.err_overflow), 32'd0);
        end

        // T4 errors
        cyc(1, 1, 0, 2'd0, 8'h00, 4'b0010);
        chk("t4_underflow", 32'(bus.err_underflow), 32'd1);
        chk("t4_valid", 32'(bus.valid_out), 32'd0);
        cyc(1, 1, 1, 2'd1, 8'h77, 4'b0000);
        cyc(1, 1, 0, 2'd0, 8'h00, 4'b0011);
        chk("t4_err_pop", 32'(bus.err_pop), 32'd1);
        chk("t4_vc1_kept", 32'(bus.empty_vchannel1), 32'd0);
        cyc(1, 1, 0, 2'd0, 8'h00, 4'b0010);
        chk("t4_vc1_data", 32'(bus.data_out), 32'h77);

        // T5 wrap with concurrent push/pop on VC3
        cyc(1, 1, 1, 2'd3, 8'hC0, 4'b0000);
        for (int i = 1; i < 10; i++) begin
            cyc(1, 1, 1, 2'd3, 8'(8'hC0 + i), 4'b1000);
            chk("t5_data", 32'(bus.data_out), 32'(8'hC0 + i - 1));
            chk("t5_count1", 32'({bus.afull_vc[3], bus.empty_vchannel3}), 32'd0);
        end
        cyc(1, 1, 0, 2'd0, 8'h00, 4'b1000);
        chk("t5_last", 32'(bus.data_out), 32'hC9);

        // T6 mid-stream reset
        cyc(1, 1, 1, 2'd0, 8'h01, 4'b0000);
        cyc(1, 1, 1, 2'd0, 8'h02, 4'b0000);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 2'd1, 8'(8'h20 + i), 4'b0000);
        cyc(0, 1, 0, 2'd0, 8'h00, 4'b0000);
        chk("t6_empty", 32'({bus.empty_vchannel3, bus.empty_vchannel2,
                             bus.empty_vchannel1, bus.empty_vchannel0}), 32'hF);
        chk("t6_full", 32'(bus.full_vc), 32'd0);
        cyc(1, 1, 0, 2'd0, 8'h00, 4'b0001);
        chk("t6_underflow", 32'(bus.err_underflow), 32'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       pr = 4'b0001 << $urandom_range(0, 3);
            else if (r < 8)  pr = 4'b0000;
            else             pr = 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)), pr);
        end

        cyc(1, 1, 0, 2'd0, 8'h00, 4'b0000);
        @(negedge clk0);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
